// File: rtl/sum_distribute_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sum_distribute_pkg
//  Brief    : Shared constants, FSM encoding and lane helper for sum_distribute.
//  Revision : 1.0
// ============================================================================
package sum_distribute_pkg;

    localparam int LANES  = 5;
    localparam int ACC_W  = 64;
    localparam int LANE_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [LANE_W-1:0] next_lane(input logic [LANE_W-1:0] cur);
        return (cur == LANE_W'(LANES - 1)) ? '0 : cur + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sum_lane_acc.sv
`default_nettype none
// ============================================================================
//  Module   : sum_lane_acc
//  Brief    : One lane's modulo-2^64 sum and sum-of-squares accumulator.
//  Revision : 1.0
// ============================================================================
module sum_lane_acc
    import sum_distribute_pkg::*;
#(
    parameter int SAMPLE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic [ACC_W-1:0]    square,
    output logic [ACC_W-1:0]    lane_sum,
    output logic [ACC_W-1:0]    lane_sum_square
);

    // Clear wins over enable so a new frame always starts from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_sum        <= '0;
            lane_sum_square <= '0;
        end else if (clear) begin
            lane_sum        <= '0;
            lane_sum_square <= '0;
        end else if (enable) begin
            lane_sum        <= lane_sum + ACC_W'(sample);
            lane_sum_square <= lane_sum_square + square;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sum_distribute.sv
`default_nettype none
// ============================================================================
//  Module   : sum_distribute
//  Brief    : Round-robins a sample frame over five lanes, accumulating sums
//             and sums of squares through a three-stage pipeline.
//  Revision : 1.0
// ============================================================================
module sum_distribute #(
    parameter int LANES    = 5,
    parameter int SAMPLE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [31:0]         frame_len,
    input  logic [SAMPLE_W-1:0] sample_data,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                busy,
    output logic                done,
    output logic [63:0]         sum_0,
    output logic [63:0]         sum_1,
    output logic [63:0]         sum_2,
    output logic [63:0]         sum_3,
    output logic [63:0]         sum_4,
    output logic [63:0]         sum_square_0,
    output logic [63:0]         sum_square_1,
    output logic [63:0]         sum_square_2,
    output logic [63:0]         sum_square_3,
    output logic [63:0]         sum_square_4
);

    import sum_distribute_pkg::*;

    state_t              state;
    state_t              state_next;
    logic [31:0]         frame_len_q;
    logic [31:0]         accept_count;
    logic [LANE_W-1:0]   lane_idx;
    logic                drain_cnt;

    logic                start_ok;
    logic                accept;
    logic                last_accept;

    logic                s1_valid;
    logic [SAMPLE_W-1:0] s1_sample;
    logic [LANE_W-1:0]   s1_lane;

    logic                s2_valid;
    logic [SAMPLE_W-1:0] s2_sample;
    logic [LANE_W-1:0]   s2_lane;
    logic [ACC_W-1:0]    s2_square;

    logic [ACC_W-1:0]    lane_sum        [LANES];
    logic [ACC_W-1:0]    lane_sum_square [LANES];

    assign start_ok     = (state == ST_IDLE) && start;
    assign sample_ready = (state == ST_RUN);
    assign accept       = sample_valid && sample_ready;
    assign last_accept  = accept && (accept_count == (frame_len_q - 32'd1));
    assign busy         = (state != ST_IDLE);
    assign done         = (state == ST_DONE);

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = (frame_len == 32'd0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_accept) begin
                    state_next = ST_DRAIN;
                end
            end
            // Two drain cycles let the final sample clear stages 2 and 3.
            ST_DRAIN: begin
                if (drain_cnt) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            frame_len_q  <= '0;
            accept_count <= '0;
            lane_idx     <= '0;
            drain_cnt    <= 1'b0;
        end else begin
            state     <= state_next;
            drain_cnt <= (state == ST_DRAIN) ? ~drain_cnt : 1'b0;
            if (start_ok) begin
                frame_len_q  <= frame_len;
                accept_count <= '0;
                lane_idx     <= '0;
            end else if (accept) begin
                accept_count <= accept_count + 32'd1;
                lane_idx     <= next_lane(lane_idx);
            end
        end
    end

    // Data registers only load on a live beat; the valid bits mask bubbles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_sample <= '0;
            s1_lane   <= '0;
            s2_valid  <= 1'b0;
            s2_sample <= '0;
            s2_lane   <= '0;
            s2_square <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_sample <= sample_data;
                s1_lane   <= lane_idx;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sample <= s1_sample;
                s2_lane   <= s1_lane;
                s2_square <= ACC_W'(s1_sample) * ACC_W'(s1_sample);
            end
        end
    end

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lanes
            sum_lane_acc #(
                .SAMPLE_W (SAMPLE_W)
            ) u_lane (
                .clk             (clk),
                .reset           (reset),
                .clear           (start_ok),
                .enable          (s2_valid && (s2_lane == LANE_W'(k))),
                .sample          (s2_sample),
                .square          (s2_square),
                .lane_sum        (lane_sum[k]),
                .lane_sum_square (lane_sum_square[k])
            );
        end
    endgenerate

    assign sum_0        = lane_sum[0];
    assign sum_1        = lane_sum[1];
    assign sum_2        = lane_sum[2];
    assign sum_3        = lane_sum[3];
    assign sum_4        = lane_sum[4];
    assign sum_square_0 = lane_sum_square[0];
    assign sum_square_1 = lane_sum_square[1];
    assign sum_square_2 = lane_sum_square[2];
    assign sum_square_3 = lane_sum_square[3];
    assign sum_square_4 = lane_sum_square[4];

endmodule
`default_nettype wire

// File: tb/tb_sum_distribute.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sum_distribute
//  Brief    : Randomised self-checking bench for sum_distribute.
//  Revision : 1.0
// ============================================================================
module tb_sum_distribute;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] frame_len;
    logic [31:0] sample_data;
    logic        sample_valid;
    logic        sample_ready;
    logic        busy;
    logic        done;
    logic [63:0] sum_o [5];
    logic [63:0] sq_o  [5];

    int          checks = 0;
    int          errors = 0;
    logic [31:0] stim_q [$];
    logic [63:0] exp_sum [5];
    logic [63:0] exp_sq  [5];
    logic [63:0] exp_total;

    always #5 clk = ~clk;

    sum_distribute #(
        .LANES    (5),
        .SAMPLE_W (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .frame_len    (frame_len),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy),
        .done         (done),
        .sum_0        (sum_o[0]),
        .sum_1        (sum_o[1]),
        .sum_2        (sum_o[2]),
        .sum_3        (sum_o[3]),
        .sum_4        (sum_o[4]),
        .sum_square_0 (sq_o[0]),
        .sum_square_1 (sq_o[1]),
        .sum_square_2 (sq_o[2]),
        .sum_square_3 (sq_o[3]),
        .sum_square_4 (sq_o[4])
    );

    task automatic check_val(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Reference: sample n lands in lane n mod 5; totals wrap naturally at 64 bits.
    task automatic build_model();
        for (int k = 0; k < 5; k++) begin
            exp_sum[k] = '0;
            exp_sq[k]  = '0;
        end
        exp_total = '0;
        foreach (stim_q[n]) begin
            exp_sum[n % 5] += 64'(stim_q[n]);
            exp_sq[n % 5]  += 64'(stim_q[n]) * 64'(stim_q[n]);
            exp_total      += 64'(stim_q[n]);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [63:0] combined;
        combined = '0;
        for (int k = 0; k < 5; k++) begin
            check_val($sformatf("%s_sum%0d", tag, k), sum_o[k], exp_sum[k]);
            check_val($sformatf("%s_sq%0d", tag, k), sq_o[k], exp_sq[k]);
            combined += sum_o[k];
        end
        check_val($sformatf("%s_total", tag), combined, exp_total);
    endtask

    task automatic check_zero(input string tag);
        check_val($sformatf("%s_busy", tag), 64'(busy), 64'd0);
        check_val($sformatf("%s_done", tag), 64'(done), 64'd0);
        check_val($sformatf("%s_ready", tag), 64'(sample_ready), 64'd0);
        for (int k = 0; k < 5; k++) begin
            check_val($sformatf("%s_sum%0d", tag, k), sum_o[k], 64'd0);
            check_val($sformatf("%s_sq%0d", tag, k), sq_o[k], 64'd0);
        end
    endtask

    // Called at #1 after a rising edge with the DUT idle.
    task automatic run_frame(input string tag, input int gap_mode, input bit disturb);
        int len;
        int idx;
        int cyc;
        bit v;
        len = stim_q.size();
        idx = 0;
        cyc = 0;
        build_model();
        frame_len = len;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        frame_len = $urandom;
        check_val({tag, "_busy0"}, 64'(busy), 64'd1);
        if (len == 0) begin
            check_val({tag, "_done0"}, 64'(done), 64'd1);
            check_val({tag, "_ready0"}, 64'(sample_ready), 64'd0);
            check_outputs({tag, "_z"});
            @(posedge clk); #1;
            check_val({tag, "_idle_busy"}, 64'(busy), 64'd0);
            check_val({tag, "_idle_done"}, 64'(done), 64'd0);
            check_val({tag, "_idle_ready"}, 64'(sample_ready), 64'd0);
            return;
        end
        while (idx < len) begin
            if (cyc > 4 * len + 20) begin
                check_val({tag, "_timeout"}, 64'd0, 64'd1);
                break;
            end
            check_val({tag, "_ready"}, 64'(sample_ready), 64'd1);
            check_val({tag, "_nodone"}, 64'(done), 64'd0);
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            start        = (disturb && cyc == 2);
            frame_len    = $urandom;
            sample_valid = v;
            sample_data  = v ? stim_q[idx] : 32'($urandom);
            @(posedge clk); #1;
            if (v) idx++;
            cyc++;
        end
        sample_valid = 1'b0;
        start        = 1'b0;
        check_val({tag, "_drain1_ready"}, 64'(sample_ready), 64'd0);
        check_val({tag, "_drain1_busy"}, 64'(busy), 64'd1);
        check_val({tag, "_drain1_done"}, 64'(done), 64'd0);
        @(posedge clk); #1;
        check_val({tag, "_drain2_done"}, 64'(done), 64'd0);
        @(posedge clk); #1;
        check_val({tag, "_done"}, 64'(done), 64'd1);
        check_outputs({tag, "_res"});
        @(posedge clk); #1;
        check_val({tag, "_after_done"}, 64'(done), 64'd0);
        check_val({tag, "_after_busy"}, 64'(busy), 64'd0);
        check_outputs({tag, "_hold"});
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        frame_len    = '0;
        sample_data  = '0;
        sample_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("por");
        reset = 1'b0;
        @(posedge clk); #1;

        stim_q = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
        run_frame("seq5", 0, 1'b0);
        check_val("seq5_sq4_const", sq_o[4], 64'd25);

        stim_q = '{32'd3, 32'd3, 32'd3, 32'd3, 32'd3, 32'd3, 32'd3};
        run_frame("toggle7", 1, 1'b0);
        check_val("toggle7_sum0_const", sum_o[0], 64'd6);
        check_val("toggle7_sq2_const", sq_o[2], 64'd9);

        stim_q.delete();
        run_frame("len0", 0, 1'b0);

        stim_q.delete();
        repeat (6) stim_q.push_back(32'hFFFF_FFFF);
        run_frame("wrap6", 0, 1'b0);
        check_val("wrap6_sq0_const", sq_o[0], 64'hFFFF_FFFC_0000_0002);
        check_val("wrap6_sq1_const", sq_o[1], 64'hFFFF_FFFE_0000_0001);

        stim_q.delete();
        repeat (8) stim_q.push_back(32'($urandom));
        run_frame("restart", 2, 1'b1);

        stim_q = '{32'($urandom)};
        run_frame("len1", 2, 1'b0);

        for (int r = 0; r < 6; r++) begin
            stim_q.delete();
            repeat ($urandom_range(2, 30)) stim_q.push_back(32'($urandom));
            run_frame($sformatf("rnd%0d", r), r % 3, 1'b0);
        end

        // Reset after three accepts of a ten-sample frame.
        frame_len = 32'd10;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample_valid = 1'b1;
            sample_data  = 32'($urandom);
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #2;
        check_zero("rst_async");
        @(posedge clk); #1;
        check_zero("rst_next");
        reset        = 1'b0;
        sample_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check_val("rst_nodone", 64'(done), 64'd0);
            check_val("rst_idle", 64'(busy), 64'd0);
        end

        stim_q.delete();
        repeat (10) stim_q.push_back(32'($urandom));
        run_frame("post_rst", 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sum_distribute.md
SUM_DISTRIBUTE -- requirements
Module: sum_distribute

Interface
REQ-001 Parameter LANES, default 5, number of partial-sum lanes; fixed at 5 for this design.
REQ-002 Parameter SAMPLE_W, default 32, unsigned sample width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a frame; honoured only in IDLE.
REQ-006 frame_len  input  32  number of samples in the frame; latched on an honoured start.
REQ-007 sample_data  input  SAMPLE_W  unsigned sample.
REQ-008 sample_valid  input  1  sample_data is valid this cycle.
REQ-009 sample_ready  output  1  block accepts a sample this cycle.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse when all lane results are final.
REQ-012 sum_0..sum_4  output  64 each  per-lane sample sums.
REQ-013 sum_square_0..sum_square_4  output  64 each  per-lane sums of squared samples.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-015 IDLE + start SHALL latch frame_len, clear all ten accumulators, set lane index to 0 and accepted count to 0; go to RUN if frame_len != 0, otherwise to DONE.
REQ-016 A sample SHALL be accepted only on a cycle with sample_valid && sample_ready; sample_ready SHALL be 1 only in RUN.
REQ-017 Accepted sample n (n from 0) SHALL go to lane n mod 5; the lane index wraps 4 -> 0.
REQ-018 Pipeline: stage 1 registers sample and lane; stage 2 registers the 64-bit square; stage 3 adds sample (zero-extended) to sum_k and square to sum_square_k.
REQ-019 Accumulation SHALL be modulo 2^64; there is no saturation and no overflow flag.
REQ-020 The accepting edge of sample frame_len-1 SHALL move RUN -> DRAIN; DRAIN lasts exactly 2 cycles, then DONE.
REQ-021 DONE SHALL last 1 cycle with done=1, then return to IDLE; done SHALL be 0 in all other states.
REQ-022 Gaps in sample_valid SHALL stall counting only; pipeline stages SHALL carry a valid bit, and bubbles SHALL not alter the accumulators.
REQ-023 start outside IDLE SHALL be ignored; frame_len changes outside an honoured start SHALL have no effect.
REQ-024 In IDLE and DONE, sum/sum_square outputs SHALL hold their final values until the next honoured start.
REQ-025 Combining the lane outputs (5-way add) SHALL equal the frame total modulo 2^64.

Reset
REQ-026 Asserting reset at any time SHALL force IDLE, with busy=0, done=0, sample_ready=0, all sums 0, counters 0 and pipeline valids 0.
REQ-027 Reset mid-frame SHALL discard the frame; no done pulse SHALL follow.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding, LANES=5 and the 64-bit accumulator width constant.
REQ-029 One sub-module, sum_lane_acc (one lane's sum and sum_square accumulator with clear and enable), SHALL be instantiated 5 times.

Verification
REQ-030 frame_len=5, samples 1,2,3,4,5 back-to-back -> sums 1,2,3,4,5; squares 1,4,9,16,25; done exactly 3 cycles after the last accept.
REQ-031 frame_len=7, all samples 3, valid toggled 1/0 -> sum_0=sum_1=6, sum_2..4=3; sum_square_0=sum_square_1=18, others 9.
REQ-032 frame_len=0 -> busy for 1 cycle, done the next cycle, all outputs 0, sample_ready never 1.
REQ-033 frame_len=6, all samples 0xFFFFFFFF -> sum_0=0x1FFFFFFFE, sum_square_0=0xFFFFFFFC00000002 (wrapped); other lanes 0xFFFFFFFF and 0xFFFFFFFE00000001.
REQ-034 start pulsed during RUN -> ignored; results match the original frame.
REQ-035 reset asserted after 3 accepts of a 10-sample frame -> all outputs 0 on the next cycle, no done; a new frame then runs correctly.
